// File: rtl/nibble_serial_adder_seq_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer:
// FSM state encoding and the width of one lookahead slice.
package nibble_serial_adder_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_seq_cla4_slice.sv
// One 4-bit carry-lookahead slice: per-bit carries, nibble sum and the
// block propagate/generate terms used to chain nibbles.
module cla4_slice
    import nibble_serial_adder_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    input  logic                i_c_in,
    output logic [NIBBLE_W-1:0] o_sum,
    output logic [NIBBLE_W-1:0] o_c,
    output logic                o_bp,
    output logic                o_bg
);

    logic [NIBBLE_W-1:0] w_p;
    logic [NIBBLE_W-1:0] w_g;

    assign w_p = i_a ^ i_b;
    assign w_g = i_a & i_b;

    // Every carry is a two-level function of P, G and the slice carry-in.
    assign o_c[0] = w_g[0] | (w_p[0] & i_c_in);
    assign o_c[1] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c_in);
    assign o_c[2] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_c_in);
    assign o_c[3] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c_in);

    assign o_sum = w_p ^ {o_c[2:0], i_c_in};
    assign o_bp  = &w_p;
    assign o_bg  = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

endmodule

// File: rtl/nibble_serial_adder_seq.sv
// Multi-cycle add/subtract controller: one shared 4-bit lookahead slice
// processes the operands a nibble per cycle, LSB nibble first.
module nibble_serial_adder_seq
    import nibble_serial_adder_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c_in,
    input  logic             i_sub,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_c_out,
    output logic             o_ovf,
    output logic             o_all_prop
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic               r_acc;
    logic [WIDTH-1:0]   r_sum;
    logic               r_busy;
    logic               r_done;
    logic               r_c_out;
    logic               r_ovf;
    logic               r_all_prop;

    logic [NIBBLE_W-1:0] w_slice_sum;
    logic [NIBBLE_W-1:0] w_c;
    logic                w_bp;
    logic                w_bg;
    logic                w_carry_next;
    logic [WIDTH-1:0]    w_sum_next;
    logic                w_unused_c;

    // Operands shift right each RUN cycle, so the active nibble is always the bottom one.
    cla4_slice u_slice (
        .i_a    (r_opa[NIBBLE_W-1:0]),
        .i_b    (r_opb[NIBBLE_W-1:0]),
        .i_c_in (r_carry),
        .o_sum  (w_slice_sum),
        .o_c    (w_c),
        .o_bp   (w_bp),
        .o_bg   (w_bg)
    );

    assign w_carry_next = w_bg | (w_bp & r_carry);
    assign w_unused_c   = ^w_c[1:0];

    // Result nibbles enter at the top and move down; after NIB steps they sit in place.
    generate
        if (NIB == 1) begin : g_single_nib
            assign w_sum_next = w_slice_sum;
        end else begin : g_multi_nib
            assign w_sum_next = {w_slice_sum, r_sum[WIDTH-1:NIBBLE_W]};
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_opa      <= '0;
            r_opb      <= '0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            r_acc      <= 1'b0;
            r_sum      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_c_out    <= 1'b0;
            r_ovf      <= 1'b0;
            r_all_prop <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_opa   <= i_a;
                        r_opb   <= i_sub ? ~i_b : i_b;
                        r_carry <= i_sub ? 1'b1 : i_c_in;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_acc   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_carry_next;
                    r_acc   <= r_acc & w_bp;
                    r_opa   <= r_opa >> NIBBLE_W;
                    r_opb   <= r_opb >> NIBBLE_W;
                    if (r_idx == LAST_IDX) begin
                        r_c_out    <= w_c[3];
                        r_ovf      <= w_c[3] ^ w_c[2];
                        r_all_prop <= r_acc & w_bp;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_sum      = r_sum;
    assign o_c_out    = r_c_out;
    assign o_ovf      = r_ovf;
    assign o_all_prop = r_all_prop;

endmodule

// File: tb/tb_nibble_serial_adder_seq.sv
// Directed bench for nibble_serial_adder_seq at WIDTH=16: vector table plus
// start-hold and mid-operation reset sequences.
module tb_nibble_serial_adder_seq;

    localparam int WIDTH = 16;
    localparam int LAT   = 5;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        ap;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             all_prop;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[9];

    nibble_serial_adder_seq #(.WIDTH(WIDTH)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_a        (a),
        .i_b        (b),
        .i_c_in     (c_in),
        .i_sub      (sub),
        .o_busy     (busy),
        .o_done     (done),
        .o_sum      (sum),
        .o_c_out    (c_out),
        .o_ovf      (ovf),
        .o_all_prop (all_prop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Runs one operation; lat is the cycle after acceptance in which done was seen (0 = timeout).
    task automatic do_op(input logic [15:0] ia, input logic [15:0] ib, input logic icin,
                         input logic isub, output int lat, output bit busy_ok);
        @(negedge clk);
        a = ia; b = ib; c_in = icin; sub = isub; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~ia; b = ~ib; sub = ~isub; c_in = ~icin;
        lat = 0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    initial begin
        int lat;
        bit busy_ok;
        int done_cnt;
        logic [15:0] s5, s11;
        logic d5, d6, b6, b7, d11, co11;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", c_out, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_allprop", all_prop, 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat, busy_ok);
            chk($sformatf("v%0d_latency", i), lat, LAT);
            chk($sformatf("v%0d_busy", i), busy_ok, 1);
            chk($sformatf("v%0d_sum", i), sum, vecs[i].sum);
            chk($sformatf("v%0d_cout", i), c_out, vecs[i].cout);
            chk($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
            chk($sformatf("v%0d_allprop", i), all_prop, vecs[i].ap);
            @(negedge clk);
            chk($sformatf("v%0d_hold", i), {done, sum}, {1'b0, vecs[i].sum});
        end

        // start held high across RUN/DONE: only one operation until IDLE returns
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; c_in = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        a = 16'hFFFF;
        done_cnt = 0;
        s5 = '0; s11 = '0; d5 = 0; d6 = 0; b6 = 0; b7 = 0; d11 = 0; co11 = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (k == 5)  begin d5 = done; s5 = sum; end
            if (k == 6)  begin d6 = done; b6 = busy; end
            if (k == 7)  begin b7 = busy; start = 1'b0; end
            if (k == 11) begin d11 = done; s11 = sum; co11 = c_out; end
        end
        chk("hold_first_done", d5, 1);
        chk("hold_first_sum", s5, 16'h0002);
        chk("hold_idle_gap", {d6, b6}, 2'b00);
        chk("hold_second_busy", b7, 1);
        chk("hold_second_done", d11, 1);
        chk("hold_second_sum", {co11, s11}, {1'b1, 16'h0000});
        chk("hold_done_count", done_cnt, 2);

        // reset during RUN aborts without a done pulse
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; c_in = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (k == 2) rst = 1'b1;
            if (k == 3) begin
                chk("abort_outputs", {busy, done, sum, c_out, ovf, all_prop}, '0);
                rst = 1'b0;
            end
        end
        chk("abort_no_done", done_cnt, 0);
        do_op(16'h0F0F, 16'h0101, 1'b1, 1'b0, lat, busy_ok);
        chk("after_abort_latency", lat, LAT);
        chk("after_abort_busy", busy_ok, 1);
        chk("after_abort_sum", {c_out, ovf, sum}, {1'b0, 1'b0, 16'h1011});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
